control_unit: RTL and testbench
===============================

Name: control_unit

Overview:
Hardwired Moore control sequencer for the Mini SRC datapath. It sits directly upstream of DataPath and drives every DataPath control input. It steps fetch (T0–T2) and per-opcode execute steps (T3–T7) from the IR opcode and CON_FF. Halt and stop requests freeze the sequencer.

Parameters:
OPW, 5, opcode width (ir[31:27])
ALUW, 5, aluControl width

Ports:
clock  in  1  system clock; state advances on rising edge
clear  in  1  asynchronous, active-low reset
ir  in  32  instruction register contents; only ir[31:27] used
CON_FF  in  1  branch condition flip-flop from datapath
stop  in  1  request halt at next instruction boundary
run  out  1  1 while sequencing, 0 in RESET/HALT
PCout, IncPC, ZLOout, ZLOin, Cout, MDRout, RAMenable, MARin, PCin, MDRin, IRin, Yin  out  1 each  datapath strobes
Gra, Grb, Grc, Rin, Rout, BAout, R15in  out  1 each  register-select/file strobes
read, write, conin  out  1 each  memory/condition strobes
ZMuxEnable, ZSelect, ZMuxOut  out  1 each  Z-mux to bus (ZSelect=0 selects Z low)
OutPortenable, PortInout  out  1 each  out-port load / in-port drive bus
aluControl  out  ALUW  ALU operation code

Behaviour:
- States: RESET, T0..T7, HALT. Outputs decode only from state and latched opcode (Moore). Any strobe not listed for a state is 0. aluControl is 0 unless listed.
- clear=0, asynchronously: state=RESET, all outputs 0, run=0. First rising edge after release goes to T0. Reset mid-instruction abandons it, with no partial strobes.
- Fetch, for all opcodes:
  - T0: PCout, MARin, IncPC.
  - T1: read, RAMenable, MDRin.
  - T2: MDRout, IRin.
  - Opcode is sampled from ir during T3 and held (registered) until the instruction ends.
- Reg-reg ALU (add 00011 … shl 01011): T3 Grb,Rout,Yin; T4 Grc,Rout,ZLOin, aluControl=opcode; T5 ZMuxEnable,ZMuxOut,Gra,Rin.
- neg 10001 / not 10010: T3 Grb,Rout,ZLOin, aluControl=opcode; T4 Z→bus, Gra,Rin.
- Immediate (addi 01100 / andi 01101 / ori 01110): T3 Grb,Rout,Yin; T4 Cout,ZLOin, aluControl=00011/00101/00110 respectively; T5 Z→bus, Gra,Rin.
- ldi 00001: T3 Grb,BAout,Yin; T4 Cout,ZLOin, aluControl=00011; T5 Z→bus, Gra,Rin.
- ld 00000: T3–T4 as ldi; T5 Z→bus, MARin; T6 read,RAMenable,MDRin; T7 MDRout,Gra,Rin.
- st 00010: T3–T5 as ld; T6 Gra,Rout,MDRin (read=0); T7 write,RAMenable.
- br 10011: T3 Gra,Rout,conin; T4 PCout,Yin; T5 Cout,ZLOin, aluControl=00011; T6 Z→bus, PCin if CON_FF=1, else all strobes 0.
- jr 10100: T3 Gra,Rout,PCin.
- jal 10101: T3 PCout,R15in; T4 Gra,Rout,PCin.
- in 10110: T3 PortInout,Gra,Rin.
- out 10111: T3 Gra,Rout,OutPortenable.
- nop 11010: ends after T3 (T3 has no strobes). Unsupported opcodes (mul, div, mfhi, mflo, 11100–11111) behave exactly as nop.
- halt 11011: T3 → HALT. HALT holds all outputs 0 and run=0 until clear=0.
- Instruction boundary:
  - After the last listed step, next state is T0.
  - If stop=1 on that edge, next state is HALT instead.
  - stop is ignored at all other edges.

Optional Feature:
SINGLE_STEP_EN.
- Defined: adds input step_req (1 bit) and state PAUSE.
  - Each instruction boundary enters PAUSE (outputs 0, run=1).
  - PAUSE → T0 on the first edge with step_req=1.
  - stop=1 at the boundary still wins and goes to HALT.
- Undefined: no step_req port and no PAUSE state; the boundary goes directly to T0.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - opcode localparams (OP_LD … OP_HALT);
  - ALU code localparams;
  - state encoding typedef/localparams (S_RESET, S_T0..S_T7, S_HALT, S_PAUSE);
  - instruction-class enum (CLS_RRALU, CLS_UNALU, CLS_IMM, CLS_LDI, CLS_LD, CLS_ST, CLS_BR, CLS_JR, CLS_JAL, CLS_IN, CLS_OUT, CLS_NOP, CLS_HALT).
- One natural sub-module: op_decoder, combinational opcode → class and imm aluControl mapping.

Test Plan:
- clear=0 mid-T4 of add → all outputs 0 immediately, run=0; after release, T0 asserts PCout,MARin,IncPC exactly one cycle later.
- ir=0x6A28_0045 (andi) → T3 Grb,Rout,Yin; T4 Cout,ZLOin, aluControl=00101; T5 ZMuxEnable,ZMuxOut,Gra,Rin; then T0.
- ir=0x0000_0010 (ld) → T5 MARin with Z→bus; T6 read,RAMenable,MDRin; T7 MDRout,Gra,Rin; 8 cycles total per instruction.
- ir=0x9800_0003 (br): CON_FF=1 → PCin in T6; CON_FF=0 → T6 all strobes 0; both return to T0.
- ir=0xD800_0000 (halt) → HALT after T3, run=0, outputs stay 0 for 20 cycles; ir=0xD000_0000 (nop) → back to T0 after T3.
- stop=1 held during T3 of andi → ignored; stop=1 on the T5 edge → HALT, no T0 fetch.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared opcodes, ALU codes, states and instruction classes for control_unit
package cpu_ctrl_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_JAL  = 5'b10101;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [4:0] ALU_ADD = 5'b00011;
    localparam logic [4:0] ALU_AND = 5'b00101;
    localparam logic [4:0] ALU_OR  = 5'b00110;

    // T3..T7 must stay consecutive: the sequencer advances by incrementing.
    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT, S_PAUSE
    } state_t;

    typedef enum logic [3:0] {
        CLS_RRALU, CLS_UNALU, CLS_IMM, CLS_LDI, CLS_LD, CLS_ST, CLS_BR,
        CLS_JR, CLS_JAL, CLS_IN, CLS_OUT, CLS_NOP, CLS_HALT
    } op_class_t;

    // Final execute step of each class; the instruction boundary follows it.
    function automatic state_t last_step(input op_class_t cls);
        case (cls)
            CLS_RRALU, CLS_IMM, CLS_LDI: return S_T5;
            CLS_UNALU, CLS_JAL:          return S_T4;
            CLS_LD, CLS_ST:              return S_T7;
            CLS_BR:                      return S_T6;
            default:                     return S_T3;
        endcase
    endfunction

endpackage

// File: rtl/op_decoder.sv
// rtl/op_decoder.sv - opcode to instruction class and immediate ALU code
// Ports: opcode (in, 5) ; op_class (out, class enum) ; imm_alu (out, 5) ALU code for addi/andi/ori/ldi/ld/st/br
module op_decoder
    import cpu_ctrl_pkg::*;
(
    input  logic [4:0] opcode,
    output op_class_t  op_class,
    output logic [4:0] imm_alu
);

    always_comb begin
        op_class = CLS_NOP;
        imm_alu  = ALU_ADD;
        if (opcode >= OP_ADD && opcode <= OP_SHL) begin
            op_class = CLS_RRALU;
        end else begin
            case (opcode)
                OP_LD:   op_class = CLS_LD;
                OP_LDI:  op_class = CLS_LDI;
                OP_ST:   op_class = CLS_ST;
                OP_ADDI: op_class = CLS_IMM;
                OP_ANDI: begin op_class = CLS_IMM; imm_alu = ALU_AND; end
                OP_ORI:  begin op_class = CLS_IMM; imm_alu = ALU_OR;  end
                OP_NEG,
                OP_NOT:  op_class = CLS_UNALU;
                OP_BR:   op_class = CLS_BR;
                OP_JR:   op_class = CLS_JR;
                OP_JAL:  op_class = CLS_JAL;
                OP_IN:   op_class = CLS_IN;
                OP_OUT:  op_class = CLS_OUT;
                OP_HALT: op_class = CLS_HALT;
                // mul, div, mfhi, mflo, nop and the unassigned codes all run as nop
                default: op_class = CLS_NOP;
            endcase
        end
    end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - hardwired Moore control sequencer for the Mini SRC datapath
// Ports: clock, clear (async active-low), ir[31:0], CON_FF, stop in; run and all datapath
// strobes out; aluControl[ALUW-1:0] out. Optional macro SINGLE_STEP_EN adds input step_req
// and a PAUSE state entered at every instruction boundary.
module control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int OPW  = 5,
    parameter int ALUW = 5
) (
    input  logic            clock,
    input  logic            clear,
    input  logic [31:0]     ir,
    input  logic            CON_FF,
    input  logic            stop,
`ifdef SINGLE_STEP_EN
    input  logic            step_req,
`endif
    output logic            run,
    output logic            PCout, IncPC, ZLOout, ZLOin, Cout, MDRout, RAMenable,
    output logic            MARin, PCin, MDRin, IRin, Yin,
    output logic            Gra, Grb, Grc, Rin, Rout, BAout, R15in,
    output logic            read, write, conin,
    output logic            ZMuxEnable, ZSelect, ZMuxOut,
    output logic            OutPortenable, PortInout,
    output logic [ALUW-1:0] aluControl
);

`ifdef SINGLE_STEP_EN
    localparam state_t S_BOUNDARY = S_PAUSE;
`else
    localparam state_t S_BOUNDARY = S_T0;
`endif

    state_t          state;
    logic [OPW-1:0]  op_q;
    logic [OPW-1:0]  op_eff;
    op_class_t       op_class;
    logic [4:0]      imm_alu;
    logic            unused_ir;

    assign unused_ir = ^ir[31-OPW:0];

    // IR is loaded at the end of T2, so T3 decodes the live IR; later steps use the
    // copy captured on the T3 edge in case IR changes underneath the instruction.
    assign op_eff = (state == S_T3) ? ir[31 -: OPW] : op_q;

    op_decoder u_op_decoder (
        .opcode   (op_eff),
        .op_class (op_class),
        .imm_alu  (imm_alu)
    );

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state <= S_RESET;
            op_q  <= '0;
        end else begin
            case (state)
                S_RESET: state <= S_T0;
                S_T0:    state <= S_T1;
                S_T1:    state <= S_T2;
                S_T2:    state <= S_T3;
                S_T3, S_T4, S_T5, S_T6, S_T7: begin
                    if (state == S_T3) op_q <= ir[31 -: OPW];
                    if (op_class == CLS_HALT)
                        state <= S_HALT;
                    else if (state == last_step(op_class))
                        state <= stop ? S_HALT : S_BOUNDARY;
                    else
                        state <= state_t'(state + 4'd1);
                end
                S_HALT:  state <= S_HALT;
`ifdef SINGLE_STEP_EN
                S_PAUSE: if (step_req) state <= S_T0;
`endif
                default: state <= S_RESET;
            endcase
        end
    end

    always_comb begin
        run = 1'b0;
        PCout = 1'b0; IncPC = 1'b0; ZLOout = 1'b0; ZLOin = 1'b0; Cout = 1'b0;
        MDRout = 1'b0; RAMenable = 1'b0; MARin = 1'b0; PCin = 1'b0; MDRin = 1'b0;
        IRin = 1'b0; Yin = 1'b0; Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0;
        Rout = 1'b0; BAout = 1'b0; R15in = 1'b0; read = 1'b0; write = 1'b0;
        conin = 1'b0; ZMuxEnable = 1'b0; ZSelect = 1'b0; ZMuxOut = 1'b0;
        OutPortenable = 1'b0; PortInout = 1'b0;
        aluControl = '0;

        run = (state != S_RESET) && (state != S_HALT);

        case (state)
            S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; end
            S_T1: begin read = 1'b1; RAMenable = 1'b1; MDRin = 1'b1; end
            S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
            S_T3, S_T4, S_T5, S_T6, S_T7: begin
                case (op_class)
                    CLS_RRALU: begin
                        if (state == S_T3) begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                        if (state == S_T4) begin
                            Grc = 1'b1; Rout = 1'b1; ZLOin = 1'b1; aluControl = ALUW'(op_eff);
                        end
                        if (state == S_T5) begin
                            ZMuxEnable = 1'b1; ZMuxOut = 1'b1; Gra = 1'b1; Rin = 1'b1;
                        end
                    end
                    CLS_UNALU: begin
                        if (state == S_T3) begin
                            Grb = 1'b1; Rout = 1'b1; ZLOin = 1'b1; aluControl = ALUW'(op_eff);
                        end
                        if (state == S_T4) begin
                            ZMuxEnable = 1'b1; ZMuxOut = 1'b1; Gra = 1'b1; Rin = 1'b1;
                        end
                    end
                    CLS_IMM, CLS_LDI, CLS_LD, CLS_ST: begin
                        // ldi/ld/st form base+offset (BAout gives 0 for R0); immediates use Rb
                        if (state == S_T3) begin
                            Grb = 1'b1; Yin = 1'b1;
                            if (op_class == CLS_IMM) Rout = 1'b1;
                            else                     BAout = 1'b1;
                        end
                        if (state == S_T4) begin
                            Cout = 1'b1; ZLOin = 1'b1; aluControl = ALUW'(imm_alu);
                        end
                        if (state == S_T5) begin
                            ZMuxEnable = 1'b1; ZMuxOut = 1'b1;
                            if (op_class == CLS_LD || op_class == CLS_ST) MARin = 1'b1;
                            else begin Gra = 1'b1; Rin = 1'b1; end
                        end
                        if (state == S_T6) begin
                            MDRin = 1'b1;
                            if (op_class == CLS_LD) begin read = 1'b1; RAMenable = 1'b1; end
                            else begin Gra = 1'b1; Rout = 1'b1; end
                        end
                        if (state == S_T7) begin
                            if (op_class == CLS_LD) begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                            else begin write = 1'b1; RAMenable = 1'b1; end
                        end
                    end
                    CLS_BR: begin
                        if (state == S_T3) begin Gra = 1'b1; Rout = 1'b1; conin = 1'b1; end
                        if (state == S_T4) begin PCout = 1'b1; Yin = 1'b1; end
                        if (state == S_T5) begin
                            Cout = 1'b1; ZLOin = 1'b1; aluControl = ALUW'(ALU_ADD);
                        end
                        if (state == S_T6 && CON_FF) begin
                            ZMuxEnable = 1'b1; ZMuxOut = 1'b1; PCin = 1'b1;
                        end
                    end
                    CLS_JR:  begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                    CLS_JAL: begin
                        if (state == S_T3) begin PCout = 1'b1; R15in = 1'b1; end
                        if (state == S_T4) begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                    end
                    CLS_IN:  begin PortInout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    CLS_OUT: begin Gra = 1'b1; Rout = 1'b1; OutPortenable = 1'b1; end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - self-checking randomized bench for control_unit
module tb_control_unit;

    logic        clock = 1'b0;
    logic        clear;
    logic [31:0] ir;
    logic        CON_FF;
    logic        stop;
    logic        step_req = 1'b1;
    logic        run;
    logic        PCout, IncPC, ZLOout, ZLOin, Cout, MDRout, RAMenable, MARin, PCin, MDRin, IRin, Yin;
    logic        Gra, Grb, Grc, Rin, Rout, BAout, R15in, read, write, conin;
    logic        ZMuxEnable, ZSelect, ZMuxOut, OutPortenable, PortInout;
    logic [4:0]  aluControl;

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    control_unit dut (
        .clock(clock), .clear(clear), .ir(ir), .CON_FF(CON_FF), .stop(stop),
`ifdef SINGLE_STEP_EN
        .step_req(step_req),
`endif
        .run(run), .PCout(PCout), .IncPC(IncPC), .ZLOout(ZLOout), .ZLOin(ZLOin), .Cout(Cout),
        .MDRout(MDRout), .RAMenable(RAMenable), .MARin(MARin), .PCin(PCin), .MDRin(MDRin),
        .IRin(IRin), .Yin(Yin), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
        .BAout(BAout), .R15in(R15in), .read(read), .write(write), .conin(conin),
        .ZMuxEnable(ZMuxEnable), .ZSelect(ZSelect), .ZMuxOut(ZMuxOut),
        .OutPortenable(OutPortenable), .PortInout(PortInout), .aluControl(aluControl)
    );

    logic [26:0] obs;
    assign obs = {PCout, IncPC, ZLOout, ZLOin, Cout, MDRout, RAMenable, MARin, PCin, MDRin,
                  IRin, Yin, Gra, Grb, Grc, Rin, Rout, BAout, R15in, read, write, conin,
                  ZMuxEnable, ZSelect, ZMuxOut, OutPortenable, PortInout};

    localparam logic [26:0] M_PCOUT = 27'd1 << 26, M_INCPC = 27'd1 << 25, M_ZLOIN = 27'd1 << 23;
    localparam logic [26:0] M_COUT = 27'd1 << 22, M_MDROUT = 27'd1 << 21, M_RAMEN = 27'd1 << 20;
    localparam logic [26:0] M_MARIN = 27'd1 << 19, M_PCIN = 27'd1 << 18, M_MDRIN = 27'd1 << 17;
    localparam logic [26:0] M_IRIN = 27'd1 << 16, M_YIN = 27'd1 << 15, M_GRA = 27'd1 << 14;
    localparam logic [26:0] M_GRB = 27'd1 << 13, M_GRC = 27'd1 << 12, M_RIN = 27'd1 << 11;
    localparam logic [26:0] M_ROUT = 27'd1 << 10, M_BAOUT = 27'd1 << 9, M_R15IN = 27'd1 << 8;
    localparam logic [26:0] M_READ = 27'd1 << 7, M_WRITE = 27'd1 << 6, M_CONIN = 27'd1 << 5;
    localparam logic [26:0] M_OUTP = 27'd1 << 1, M_INP = 27'd1 << 0;
    localparam logic [26:0] M_ZBUS = (27'd1 << 4) | (27'd1 << 2);

    // Expected per-cycle behaviour of one instruction: {strobes, aluControl}, one entry per cycle.
    logic [31:0] exp_q[$];

    task automatic push(input logic [26:0] s, input logic [4:0] alu);
        exp_q.push_back({s, alu});
    endtask

    task automatic build(input logic [4:0] op, input logic con);
        int o;
        o = int'(op);
        exp_q.delete();
        push(M_PCOUT | M_MARIN | M_INCPC, 5'd0);
        push(M_READ | M_RAMEN | M_MDRIN, 5'd0);
        push(M_MDROUT | M_IRIN, 5'd0);
        if (o >= 3 && o <= 11) begin
            push(M_GRB | M_ROUT | M_YIN, 5'd0);
            push(M_GRC | M_ROUT | M_ZLOIN, op);
            push(M_ZBUS | M_GRA | M_RIN, 5'd0);
        end else if (o == 17 || o == 18) begin
            push(M_GRB | M_ROUT | M_ZLOIN, op);
            push(M_ZBUS | M_GRA | M_RIN, 5'd0);
        end else if (o >= 12 && o <= 14) begin
            push(M_GRB | M_ROUT | M_YIN, 5'd0);
            push(M_COUT | M_ZLOIN, (o == 12) ? 5'd3 : (o == 13) ? 5'd5 : 5'd6);
            push(M_ZBUS | M_GRA | M_RIN, 5'd0);
        end else if (o <= 2) begin
            push(M_GRB | M_BAOUT | M_YIN, 5'd0);
            push(M_COUT | M_ZLOIN, 5'd3);
            if (o == 1) push(M_ZBUS | M_GRA | M_RIN, 5'd0);
            else begin
                push(M_ZBUS | M_MARIN, 5'd0);
                if (o == 0) begin
                    push(M_READ | M_RAMEN | M_MDRIN, 5'd0);
                    push(M_MDROUT | M_GRA | M_RIN, 5'd0);
                end else begin
                    push(M_GRA | M_ROUT | M_MDRIN, 5'd0);
                    push(M_WRITE | M_RAMEN, 5'd0);
                end
            end
        end else if (o == 19) begin
            push(M_GRA | M_ROUT | M_CONIN, 5'd0);
            push(M_PCOUT | M_YIN, 5'd0);
            push(M_COUT | M_ZLOIN, 5'd3);
            push(con ? (M_ZBUS | M_PCIN) : 27'd0, 5'd0);
        end else if (o == 20) push(M_GRA | M_ROUT | M_PCIN, 5'd0);
        else if (o == 21) begin
            push(M_PCOUT | M_R15IN, 5'd0);
            push(M_GRA | M_ROUT | M_PCIN, 5'd0);
        end else if (o == 22) push(M_INP | M_GRA | M_RIN, 5'd0);
        else if (o == 23) push(M_GRA | M_ROUT | M_OUTP, 5'd0);
        else push(27'd0, 5'd0);
    endtask

    // From mid-cycle: assert clear, expect all-zero outputs at once, release on the next negedge.
    task automatic do_reset(input string name);
        clear = 1'b0;
        #1;
        vectors++;
        if (obs !== 27'd0 || aluControl !== 5'd0 || run !== 1'b0) begin
            miscompares++;
            $display("FAIL %s: strobes=%h alu=%h run=%b, want strobes=0 alu=0 run=0",
                     name, obs, aluControl, run);
        end
        @(negedge clock);
        clear = 1'b1;
        stop  = 1'b0;
    endtask

    // Runs one instruction starting with the sequencer about to show T0 at the next negedge.
    task automatic run_instr(input string name, input logic [31:0] instr, input logic con,
                             input bit stop_end, input bit hold_stop, input int abort_at);
        logic [4:0] op;
        int n;
        op = instr[31:27];
        build(op, con);
        CON_FF = con;
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            vectors++;
            if (obs !== exp_q[i][31:5] || aluControl !== exp_q[i][4:0] || run !== 1'b1) begin
                miscompares++;
                $display("FAIL %s step %0d: strobes=%h alu=%h run=%b, want strobes=%h alu=%h run=1",
                         name, i, obs, aluControl, run, exp_q[i][31:5], exp_q[i][4:0]);
            end
            if (i == abort_at) begin
                #2;
                do_reset({name, " abort"});
                return;
            end
            stop = (i == n - 1) ? stop_end : (hold_stop ? 1'b1 : 1'($urandom));
            if (i == 2) ir = instr;
            else if (i >= 4) ir = $urandom;
        end
        if (op == 5'b11011 || stop_end) begin
            for (int c = 0; c < 20; c++) begin
                @(negedge clock);
                stop = 1'($urandom);
                ir = $urandom;
                vectors++;
                if (obs !== 27'd0 || aluControl !== 5'd0 || run !== 1'b0) begin
                    miscompares++;
                    $display("FAIL %s halt cycle %0d: strobes=%h alu=%h run=%b, want all 0 run=0",
                             name, c, obs, aluControl, run);
                end
            end
            do_reset({name, " clear"});
        end
    endtask

    task automatic test_reset();
        clear = 1'b0; stop = 1'b0; ir = 32'h0; CON_FF = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            vectors++;
            if (obs !== 27'd0 || aluControl !== 5'd0 || run !== 1'b0) begin
                miscompares++;
                $display("FAIL reset cycle %0d: strobes=%h alu=%h run=%b, want all 0 run=0",
                         c, obs, aluControl, run);
            end
        end
        clear = 1'b1;
    endtask

    task automatic test_mid_reset();
        run_instr("add_abort_t4", 32'h1884_0000, 1'b0, 1'b0, 1'b0, 4);
        run_instr("andi_after_clear", 32'h6A28_0045, 1'b0, 1'b0, 1'b0, -1);
    endtask

    task automatic test_directed();
        run_instr("andi", 32'h6A28_0045, 1'b0, 1'b0, 1'b0, -1);
        run_instr("ld", 32'h0000_0010, 1'b0, 1'b0, 1'b0, -1);
        run_instr("st", 32'h1000_0020, 1'b1, 1'b0, 1'b0, -1);
        run_instr("br_taken", 32'h9800_0003, 1'b1, 1'b0, 1'b0, -1);
        run_instr("br_not_taken", 32'h9800_0003, 1'b0, 1'b0, 1'b0, -1);
        run_instr("nop", 32'hD000_0000, 1'b0, 1'b0, 1'b0, -1);
        run_instr("jal", 32'hA880_0000, 1'b0, 1'b0, 1'b0, -1);
        run_instr("halt", 32'hD800_0000, 1'b0, 1'b0, 1'b0, -1);
    endtask

    task automatic test_stop();
        run_instr("andi_stop_held", 32'h6A28_0045, 1'b0, 1'b0, 1'b1, -1);
        run_instr("andi_stop_t5", 32'h6A28_0045, 1'b0, 1'b1, 1'b1, -1);
        run_instr("nop_after_stop", 32'hD000_0000, 1'b0, 1'b0, 1'b0, -1);
    endtask

    task automatic test_back_to_back();
        logic [31:0] instr;
        for (int k = 0; k < 60; k++) begin
            instr = $urandom;
            run_instr("random", instr, 1'($urandom), ($urandom_range(0, 9) == 0), 1'b0, -1);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_directed();
        test_mid_reset();
        test_stop();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
